sdram_pattern_master: RTL and testbench
=======================================

// Module: sdram_pattern_master
// PURPOSE
//  Avalon-MM master traffic generator that drives the Qsys SDRAM controller slave port (16-bit SDRAM).
//  Writes an LFSR pattern to a word range, then reads it back in the same order and compares each word.
//  Reports busy/done/pass/error status and a pass counter on the board LEDs.
//  Sits inside qsys_system as a custom component; its master connects to the SDRAM controller s1.
// PARAMETERS
//  ADDR_W      25        Avalon byte-address width (32 MB SDRAM)
//  DATA_W      16        data width; LFSR/compare width; fixed at 16 in this revision
//  BASE_ADDR   25'h0     byte address of the first test word; must be 2-byte aligned
//  NUM_WORDS   4096      words per pass; 1..2^(ADDR_W-1)
//  MAX_PEND    4         max outstanding reads (pipelined); 1..15
//  SEED        16'hACE1  nonzero LFSR seed for pass 0
//  LOOP        1         1: restart automatically after each passing pass; 0: stop after one pass
// PORTS
//  clk                in   1       system clock (50 MHz)
//  reset_n            in   1       synchronous active-low reset
//  start              in   1       1-cycle pulse: begin test from IDLE or DONE
//  avm_address        out  ADDR_W  byte address
//  avm_byteenable     out  2       always 2'b11
//  avm_read           out  1       read request
//  avm_write          out  1       write request
//  avm_writedata      out  16      write data
//  avm_waitrequest    in   1       slave stall; request held unchanged while high
//  avm_readdata       in   16      read data
//  avm_readdatavalid  in   1       read data valid strobe, returned in request order
//  busy               out  1       high in WRITE or READ
//  done               out  1       high in DONE
//  pass               out  1       high in DONE when error_count == 0
//  error_count        out  16      mismatching words this pass, saturating at 16'hFFFF
//  pass_count         out  8       completed error-free passes, wraps 255->0
//  led                out  8       {pass_count[4:0], pass, done, busy}
// BEHAVIOUR
//  Reset (reset_n low at posedge clk): state=IDLE; all outputs 0; counters, outstanding count cleared; LFSRs=SEED.
//  LFSR: Fibonacci x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0; seed for pass n = SEED rotated left by n mod 16.
//  Two LFSRs: gen (write data) and chk (expected read data); both loaded with the pass seed on entry to WRITE.
//  IDLE: outputs idle; start -> WRITE (word index i=0, error_count=0). start ignored in WRITE/READ.
//  WRITE: avm_write=1, avm_address=BASE_ADDR+2*i, writedata=gen. Beat accepted on cycle with write & !waitrequest:
//   gen advances, i++. After acceptance of word NUM_WORDS-1 -> READ (i=0) next cycle; write deasserted that cycle.
//  READ: avm_read=1 while i<NUM_WORDS and pend<MAX_PEND; address=BASE_ADDR+2*i; accepted on read & !waitrequest -> i++, pend++.
//   Each readdatavalid: compare readdata with chk; mismatch -> error_count++ (saturating); chk advances; pend--.
//   Accept and readdatavalid in the same cycle: pend unchanged. readdatavalid with pend==0 ignored (never counted).
//   Request held stable (address/read/write/data) while waitrequest high; read never dropped mid-stall.
//  READ -> DONE when i==NUM_WORDS and pend==0 (all responses received). First read may issue the cycle after entry.
//  DONE: done=1, pass=(error_count==0). If LOOP && pass: pass_count++ on entry, next cycle -> WRITE with next seed.
//   Otherwise remain in DONE until start (-> WRITE, error_count cleared, seed continues from pass_count).
//  error_count, pass valid and stable throughout DONE; error_count live-updates during READ.
//  Reset mid-operation: immediate return to IDLE next cycle; requests deassert even if waitrequest high
//   (controller is reset by the same reset_n in qsys_system).
//  Address arithmetic modulo 2^ADDR_W; BASE_ADDR+2*NUM_WORDS beyond range wraps, no error flagged.
// TESTING
//  Zero-wait slave model, NUM_WORDS=8, LOOP=0: start -> 8 writes 1 cycle each, addresses 0,2..14, data ACE1, LFSR seq; done, pass=1, error_count=0.
//  Slave holds waitrequest 3 cycles on write 2 -> address 4/data stable for 4 cycles, no duplicate or lost write; pass=1.
//  Read latency 5 cycles, MAX_PEND=4 -> never more than 4 reads outstanding; pend returns to 0; done after 8 responses.
//  Model corrupts word 3 readdata (xor 16'h0001) -> error_count=1, pass=0, led=8'b00000010; no auto-restart with LOOP=1.
//  LOOP=1, clean model -> pass_count 1,2,3 after successive passes; pass 1 first write data = ACE1 rotl 1 = 59C3.
//  reset_n low for 1 cycle during READ with pend=3 -> next cycle IDLE, read=0, outputs 0; late readdatavalid ignored.

Source files
------------

// File: rtl/sdram_pattern_master.sv
// sdram_pattern_master
//   Avalon-MM traffic generator for a 16-bit SDRAM controller slave.
//   Each pass writes an LFSR pattern over NUM_WORDS words starting at
//   BASE_ADDR, then reads the range back in the same order. Every returned
//   word is compared against a second LFSR that runs from the same seed.
//   Status is shown on busy/done/pass/error_count/pass_count and the LEDs.
//
// Ports
//   clk_i, reset_n_i      clock, synchronous active-low reset
//   start_i               1-cycle pulse, starts a pass from IDLE or DONE
//   avm_*_o / avm_*_i     Avalon-MM master (address, byteenable, read, write,
//                         writedata, waitrequest, readdata, readdatavalid)
//   busy_o                high in WRITE or READ
//   done_o, pass_o        high in DONE; pass_o when no word mismatched
//   error_count_o         mismatches this pass, saturating
//   pass_count_o          error-free passes completed, wraps
//   led_o                 {pass_count[4:0], pass, done, busy}
module sdram_pattern_master #(
    parameter int unsigned       ADDR_W    = 25,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       NUM_WORDS = 4096,
    parameter int unsigned       MAX_PEND  = 4,
    parameter logic [DATA_W-1:0] SEED      = 16'hACE1,
    parameter bit                LOOP      = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic [1:0]        avm_byteenable_o,
    output logic              avm_read_o,
    output logic              avm_write_o,
    output logic [DATA_W-1:0] avm_writedata_o,
    input  logic              avm_waitrequest_i,
    input  logic [DATA_W-1:0] avm_readdata_i,
    input  logic              avm_readdatavalid_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [15:0]       error_count_o,
    output logic [7:0]        pass_count_o,
    output logic [7:0]        led_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_WORDS + 1);
    localparam int unsigned PEND_W = 4;
    localparam logic [IDX_W-1:0]  NW   = IDX_W'(NUM_WORDS);
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(NUM_WORDS - 1);
    localparam logic [PEND_W-1:0] MP   = PEND_W'(MAX_PEND);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    // x^16+x^14+x^13+x^11+1, shifted left with feedback into bit 0
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
        return {s[DATA_W-2:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] s, input logic [3:0] n);
        logic [2*DATA_W-1:0] w;
        w = {s, s} << n;
        return w[2*DATA_W-1 -: DATA_W];
    endfunction

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic [DATA_W-1:0]  gen_q, gen_d;
    logic [DATA_W-1:0]  chk_q, chk_d;
    logic [15:0]        err_q, err_d;
    logic [7:0]         pc_q, pc_d;

    logic               wr_req, rd_req, rd_acc, rsp, begin_pass;
    logic [ADDR_W-1:0]  word_addr;

    assign wr_req    = (state_q == S_WRITE);
    // pend only shrinks during a stall, so rd_req cannot drop mid-stall
    assign rd_req    = (state_q == S_READ) && (idx_q < NW) && (pend_q < MP);
    assign rd_acc    = rd_req && !avm_waitrequest_i;
    // a response with nothing outstanding is stray (e.g. left over from before a reset)
    assign rsp       = avm_readdatavalid_i && (pend_q != '0);
    assign word_addr = BASE_ADDR + (ADDR_W'(idx_q) << 1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        gen_d      = gen_q;
        chk_d      = chk_q;
        err_d      = err_q;
        pc_d       = pc_q;
        begin_pass = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin_pass = 1'b1;
            end
            S_WRITE: begin
                if (!avm_waitrequest_i) begin
                    gen_d = lfsr_next(gen_q);
                    if (idx_q == LAST) begin
                        state_d = S_READ;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_READ: begin
                if (rd_acc) idx_d = idx_q + 1'b1;
                pend_d = pend_q + PEND_W'(rd_acc) - PEND_W'(rsp);
                if (rsp) begin
                    chk_d = lfsr_next(chk_q);
                    if (avm_readdata_i != chk_q && err_q != 16'hFFFF) err_d = err_q + 16'd1;
                end
                if (idx_q == NW && pend_q == '0) begin
                    state_d = S_DONE;
                    if (err_q == '0) pc_d = pc_q + 8'd1;
                end
            end
            S_DONE: begin
                if ((LOOP && err_q == '0) || start_i) begin_pass = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // pass_count already reflects the pass just completed, so it picks the next seed
        if (begin_pass) begin
            state_d = S_WRITE;
            idx_d   = '0;
            err_d   = '0;
            gen_d   = rotl(SEED, pc_q[3:0]);
            chk_d   = rotl(SEED, pc_q[3:0]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            gen_q   <= SEED;
            chk_q   <= SEED;
            err_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            gen_q   <= gen_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            pc_q    <= pc_d;
        end
    end

    assign avm_read_o       = rd_req;
    assign avm_write_o      = wr_req;
    assign avm_address_o    = (wr_req || rd_req) ? word_addr : '0;
    assign avm_writedata_o  = wr_req ? gen_q : '0;
    assign avm_byteenable_o = 2'b11;
    assign busy_o           = (state_q == S_WRITE) || (state_q == S_READ);
    assign done_o           = (state_q == S_DONE);
    assign pass_o           = done_o && (err_q == '0);
    assign error_count_o    = err_q;
    assign pass_count_o     = pc_q;
    assign led_o            = {pc_q[4:0], pass_o, done_o, busy_o};

endmodule

// File: tb/tb_sdram_pattern_master.sv
module tb_sdram_pattern_master;

    localparam int          NW   = 8;
    localparam int          MP   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        logic [24:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset_n, start, waitreq, rdv;
    logic [15:0] rdata;
    logic [24:0] addr;
    logic [1:0]  be;
    logic        rd, wr, busy, done, pass;
    logic [15:0] wdata, err;
    logic [7:0]  pc, led;

    always #10 clk = ~clk;

    sdram_pattern_master #(
        .NUM_WORDS(NW), .MAX_PEND(MP), .SEED(SEED), .LOOP(1'b1)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
        .avm_address_o(addr), .avm_byteenable_o(be), .avm_read_o(rd), .avm_write_o(wr),
        .avm_writedata_o(wdata), .avm_waitrequest_i(waitreq), .avm_readdata_i(rdata),
        .avm_readdatavalid_i(rdv), .busy_o(busy), .done_o(done), .pass_o(pass),
        .error_count_o(err), .pass_count_o(pc), .led_o(led)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] rotl(input logic [15:0] s, input int n);
        logic [15:0] r;
        r = s;
        for (int k = 0; k < n % 16; k++) r = {r[14:0], r[15]};
        return r;
    endfunction

    // scoreboard and slave model state
    wr_t         exp_wr[$];
    logic [24:0] exp_rd[$];
    rsp_t        rsp_q[$];
    logic [15:0] mem[0:NW-1];
    int          cyc = 0;
    int          lat = 1;
    bit          stall_en = 0;
    int          stall_left = 0;
    bit          corrupt = 0;
    int          out_cnt = 0;
    int          max_out = 0;
    int          wr_cycles = 0;
    int          late_rdv = 0;
    bit          post_reset = 0;
    bit          first_cap = 0;
    logic [15:0] first_wd = '0;
    int          exp_pc = 0;

    always @(posedge clk) cyc++;

    // Slave: decides at each falling edge what the DUT samples at the next rising edge.
    always @(negedge clk) begin
        rsp_t r;
        wr_t  e;
        waitreq = 1'b0;
        rdv     = 1'b0;
        if (rsp_q.size() != 0 && rsp_q[0].due == cyc + 1) begin
            r     = rsp_q.pop_front();
            rdv   = 1'b1;
            rdata = r.data;
            if (out_cnt > 0) out_cnt--;
            if (post_reset) late_rdv++;
        end
        if (wr) begin
            wr_cycles++;
            if (stall_en && addr == 25'd4 && stall_left > 0) begin
                waitreq = 1'b1;
                stall_left--;
                chk("stall_addr", addr, 25'd4);
                if (exp_wr.size() != 0) chk("stall_data", wdata, exp_wr[0].data);
            end else begin
                chk("wr_expected", 32'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", addr, e.addr);
                    chk("wr_data", wdata, e.data);
                    chk("wr_be", be, 2'b11);
                end
                if (first_cap) begin
                    first_wd  = wdata;
                    first_cap = 0;
                end
                mem[addr[3:1]] = wdata;
            end
        end
        if (rd) begin
            chk("rd_expected", 32'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) chk("rd_addr", addr, exp_rd.pop_front());
            r.due  = cyc + 1 + lat;
            r.data = mem[addr[3:1]] ^ ((corrupt && addr[3:1] == 3'd3) ? 16'h0001 : 16'h0000);
            rsp_q.push_back(r);
            out_cnt++;
        end
        if (out_cnt > max_out) max_out = out_cnt;
    end

    task automatic set_pass(input int l, input bit st, input bit cor);
        logic [15:0] g;
        g          = rotl(SEED, exp_pc);
        lat        = l;
        stall_en   = st;
        stall_left = st ? 3 : 0;
        corrupt    = cor;
        max_out    = 0;
        wr_cycles  = 0;
        first_cap  = 1;
        for (int i = 0; i < NW; i++) begin
            exp_wr.push_back('{addr: 25'(2 * i), data: g});
            exp_rd.push_back(25'(2 * i));
            g = lfsr_next(g);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!done && n < 2000);
        chk({tag, "_reach_done"}, done, 1);
    endtask

    task automatic end_checks(input string tag, input int exp_err, input int exp_wrc);
        bit p;
        p = (exp_err == 0);
        if (p) exp_pc = (exp_pc + 1) % 256;
        chk({tag, "_pass"}, pass, p);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_led"}, led, {exp_pc[4:0], p, 1'b1, 1'b0});
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wr_left"}, exp_wr.size(), 0);
        chk({tag, "_rd_left"}, exp_rd.size(), 0);
        chk({tag, "_outstanding"}, out_cnt, 0);
        chk({tag, "_max_pend_ok"}, 32'(max_out <= MP), 1);
        chk({tag, "_wr_cycles"}, wr_cycles, exp_wrc);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        waitreq = 1'b0;
        rdv     = 1'b0;
        rdata   = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err, 0);
        chk("rst_pc", pc, 0);
        chk("rst_led", led, 0);
        chk("rst_rd", rd, 0);
        chk("rst_wr", wr, 0);
        chk("rst_addr", addr, 0);
        reset_n = 1'b1;
        @(negedge clk); #1;

        // A: fast slave, 3-cycle stall on the write to address 4
        set_pass(1, 1, 0);
        pulse_start();
        chk("A_busy", busy, 1);
        wait_done("A");
        end_checks("A", 0, NW + 3);
        chk("A_first_wd", first_wd, 16'hACE1);

        // B: automatic restart with the next seed, read latency 5
        set_pass(5, 0, 0);
        wait_done("B");
        end_checks("B", 0, NW);
        chk("B_first_wd", first_wd, 16'h59C3);
        chk("B_max_out", max_out, MP);

        // C: automatic restart, word 3 corrupted on readback -> stops in DONE
        set_pass(3, 0, 1);
        wait_done("C");
        end_checks("C", 1, NW);
        repeat (10) @(negedge clk);
        #1;
        chk("C_hold_done", done, 1);
        chk("C_hold_err", err, 1);
        chk("C_hold_busy", busy, 0);
        chk("C_hold_wr", wr, 0);

        // D: restart by start from DONE, seed continues from pass_count
        set_pass(2, 0, 0);
        pulse_start();
        wait_done("D");
        end_checks("D", 0, NW);

        // E: automatic pass interrupted by reset with reads outstanding
        set_pass(5, 0, 0);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (out_cnt != 3 && n < 2000);
        chk("E_reach_pend3", 32'(out_cnt == 3), 1);
        @(negedge clk); #1;
        reset_n    = 1'b0;
        post_reset = 1;
        @(negedge clk); #1;
        reset_n = 1'b1;
        chk("E_rst_rd", rd, 0);
        chk("E_rst_wr", wr, 0);
        chk("E_rst_busy", busy, 0);
        chk("E_rst_addr", addr, 0);
        chk("E_rst_pc", pc, 0);
        chk("E_rst_led", led, 0);
        exp_wr.delete();
        exp_rd.delete();
        out_cnt = 0;
        exp_pc  = 0;
        repeat (10) @(negedge clk);
        #1;
        chk("E_late_rdv_seen", 32'(late_rdv > 0), 1);
        chk("E_late_err", err, 0);
        chk("E_late_busy", busy, 0);
        chk("E_late_done", done, 0);
        post_reset = 0;

        // F: fresh pass after reset, back on the base seed
        set_pass(1, 0, 0);
        pulse_start();
        wait_done("F");
        end_checks("F", 0, NW);
        chk("F_first_wd", first_wd, 16'hACE1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
